ldm_stm_sequencer: RTL

- Multi-cycle controller for ARM Load/Store Multiple (IR[27:25]=3'b100).
- Walks the 16-bit register list in IR[15:0] and issues one memory transfer per register, lowest register at lowest address.
- Generates each transfer address from the base register value, handshakes with memory via MOC, and produces the base-register writeback value.
- Sits between the control unit (START/DONE) and the memory interface and register file.

---
 rtl/arm_ctrl_pkg.sv | 40 ++++
 rtl/reg_list_pri_enc.sv | 20 ++
 rtl/ldm_stm_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the ARM Load/Store Multiple controller:
// sequencer state encoding, addressing modes, IR field positions, helpers.
package arm_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_XFER,
      ST_WRITEBACK,
      ST_DONE
   } lsm_state_t;

   // Addressing modes, indexed by {P,U}
   localparam logic [1:0] AM_DA = 2'b00;
   localparam logic [1:0] AM_IA = 2'b01;
   localparam logic [1:0] AM_DB = 2'b10;
   localparam logic [1:0] AM_IB = 2'b11;

   // IR field positions
   localparam int unsigned IR_OP_LSB = 25;
   localparam int unsigned IR_P_BIT  = 24;
   localparam int unsigned IR_U_BIT  = 23;
   localparam int unsigned IR_W_BIT  = 21;
   localparam int unsigned IR_L_BIT  = 20;
   localparam int unsigned IR_RN_LSB = 16;

   // IR[27:25] for Load/Store Multiple
   localparam logic [2:0] LSM_OPCODE = 3'b100;

   // Number of registers named in a 16-bit register list
   function automatic logic [4:0] popcount16(input logic [15:0] list);
      logic [4:0] cnt;
      cnt = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         cnt = cnt + {4'b0000, list[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/reg_list_pri_enc.sv
// Lowest-set-bit encoder for a 16-bit register list; valid=0 when the list is empty.
module reg_list_pri_enc (
   input  logic [15:0] list,
   output logic [3:0]  idx,
   output logic        valid
);

   // Scan upward, keeping only the first set bit found
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (list[i] && !valid) begin
            idx   = i[3:0];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-cycle LDM/STM sequencer: walks the IR register list, issues one
// memory transfer per register with MOC handshake, then optionally writes
// back the base register.
// Optional feature macro: MOC_TIMEOUT_EN (per-transfer MOC timeout with ERROR abort).
module ldm_stm_sequencer
   import arm_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic [31:0] IR,
   input  logic [31:0] BASE,
   input  logic        MOC,
   output logic        BUSY,
   output logic        DONE,
   output logic        MEM_EN,
   output logic        MEM_RW,
   output logic [31:0] ADDR,
   output logic [3:0]  REG_SEL,
   output logic        REG_WE,
   output logic        WB_EN,
   output logic [31:0] WB_VALUE,
   output logic        ERROR
);

   lsm_state_t  state, nstate;

   logic [15:0] list_q;
   logic [31:0] base_q;
   logic [31:0] addr_q;
   logic [31:0] wb_q;
   logic        p_q, u_q, w_q, l_q;
   logic        rn_hit_q;

   logic        start_ok;
   logic [15:0] ir_list;
   logic [3:0]  ir_rn;
   logic        rn_hit_d;

   logic [3:0]  cur_idx;
   logic        cur_valid;
   logic [15:0] list_next;
   logic [3:0]  nxt_idx_unused;
   logic        nxt_valid;

   logic [4:0]  n_regs;
   logic [31:0] n4;
   logic [31:0] start_addr;
   logic [31:0] wb_calc;
   logic        timeout;

   logic        unused_bits;

   assign start_ok = START && (IR[IR_OP_LSB +: 3] == LSM_OPCODE);
   assign ir_list  = IR[15:0];
   assign ir_rn    = IR[IR_RN_LSB +: 4];
   assign rn_hit_d = ir_list[ir_rn];

   assign unused_bits = ^{IR[31:28], IR[22], nxt_idx_unused};

   // Current register to transfer; also tells SETUP whether the list is empty
   reg_list_pri_enc u_cur_enc (
      .list  (list_q),
      .idx   (cur_idx),
      .valid (cur_valid)
   );

   assign list_next = list_q & ~(16'h0001 << cur_idx);

   // Remaining list after the current transfer completes; empty means last transfer
   reg_list_pri_enc u_nxt_enc (
      .list  (list_next),
      .idx   (nxt_idx_unused),
      .valid (nxt_valid)
   );

   assign n_regs = popcount16(list_q);
   assign n4     = {25'd0, n_regs, 2'b00};

   // Start address and writeback value from latched base and addressing mode
   always_comb begin
      start_addr = base_q;
      case ({p_q, u_q})
         AM_IA:   start_addr = base_q;
         AM_IB:   start_addr = base_q + 32'd4;
         AM_DA:   start_addr = base_q - n4 + 32'd4;
         AM_DB:   start_addr = base_q - n4;
         default: start_addr = base_q;
      endcase
      wb_calc = u_q ? (base_q + n4) : (base_q - n4);
   end

`ifdef MOC_TIMEOUT_EN
   logic [31:0] wait_cnt;

   // Per-transfer wait counter; cleared outside XFER and whenever a transfer completes
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wait_cnt <= '0;
      end else if ((state != ST_XFER) || MOC) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 32'd1;
      end
   end

   assign timeout = (state == ST_XFER) && !MOC &&
                    (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= nstate;
      end
   end

   // Next-state and output decode
   always_comb begin
      nstate   = state;
      BUSY     = 1'b0;
      DONE     = 1'b0;
      MEM_EN   = 1'b0;
      MEM_RW   = 1'b0;
      ADDR     = '0;
      REG_SEL  = '0;
      REG_WE   = 1'b0;
      WB_EN    = 1'b0;
      WB_VALUE = '0;
      ERROR    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_ok) nstate = ST_SETUP;
         end
         ST_SETUP: begin
            BUSY   = 1'b1;
            nstate = cur_valid ? ST_XFER : ST_DONE;
         end
         ST_XFER: begin
            BUSY    = 1'b1;
            MEM_EN  = 1'b1;
            MEM_RW  = l_q;
            ADDR    = addr_q;
            REG_SEL = cur_idx;
            if (MOC) begin
               REG_WE = l_q;
               if (!nxt_valid) nstate = w_q ? ST_WRITEBACK : ST_DONE;
            end else if (timeout) begin
               ERROR  = 1'b1;
               nstate = ST_DONE;
            end
         end
         ST_WRITEBACK: begin
            BUSY     = 1'b1;
            WB_EN    = !(l_q && rn_hit_q);
            WB_VALUE = wb_q;
            nstate   = ST_DONE;
         end
         ST_DONE: begin
            DONE   = 1'b1;
            nstate = ST_IDLE;
         end
         default: nstate = ST_IDLE;
      endcase
   end

   // Datapath: latch instruction, compute addresses, advance through the list
   always_ff @(posedge CLK) begin
      if (RESET) begin
         list_q   <= '0;
         base_q   <= '0;
         addr_q   <= '0;
         wb_q     <= '0;
         p_q      <= 1'b0;
         u_q      <= 1'b0;
         w_q      <= 1'b0;
         l_q      <= 1'b0;
         rn_hit_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  list_q   <= ir_list;
                  base_q   <= BASE;
                  p_q      <= IR[IR_P_BIT];
                  u_q      <= IR[IR_U_BIT];
                  w_q      <= IR[IR_W_BIT];
                  l_q      <= IR[IR_L_BIT];
                  rn_hit_q <= rn_hit_d;
               end
            end
            ST_SETUP: begin
               addr_q <= start_addr;
               wb_q   <= wb_calc;
            end
            ST_XFER: begin
               if (MOC) begin
                  list_q <= list_next;
                  addr_q <= addr_q + 32'd4;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
